// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: a Moore FSM sequencing fetch, decode, memory,
// execute and writeback steps, plus the combinational immediate-format and ALU decoders.
//
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   op, funct3, funct7b5    fields of the latched instruction register
//   zero                    ALU zero flag, used only for the branch decision
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc            2-bit mux selects
//   ALUControl              3-bit ALU operation
//   state                   current FSM state (debug)
module multicycle_controller #(
    parameter int unsigned SUPPORT_BNE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch, taken;
    logic       ir_write, reg_write, mem_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = StFetch;
        AdrSrc    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        alu_op    = 2'b00;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (state_q)
            StFetch: begin
                state_d   = StDecode;
                ir_write  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_d = StMemAdr;
                    7'b0110011:             state_d = StExecuteR;
                    7'b0010011:             state_d = StExecuteI;
                    7'b1100011:             state_d = StBranch;
                    7'b1101111:             state_d = StJal;
                    default:                state_d = StFetch;  // unsupported op acts as nop
                endcase
            end
            StMemAdr: begin
                state_d = op[5] ? StMemWrite : StMemRead;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                state_d = StMemWb;
                AdrSrc  = 1'b1;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            StExecuteR: begin
                state_d = StAluWb;
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            StExecuteI: begin
                state_d = StAluWb;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            StAluWb: begin
                reg_write = 1'b1;
            end
            StBranch: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            StJal: begin
                state_d   = StAluWb;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: state_d = StFetch;  // codes 11-15 recover to fetch
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = (SUPPORT_BNE != 0) && !zero;
            default: taken = 1'b0;
        endcase
    end

    // Write enables are gated by reset so an aborted instruction cannot commit anything.
    assign PCWrite  = reset & (pc_update | (branch & taken));
    assign IRWrite  = reset & ir_write;
    assign MemWrite = reset & mem_write;
    assign RegWrite = reset & reg_write;
    assign state    = state_q;

    always_comb begin
        case (op)
            7'b0000011, 7'b0010011: ImmSrc = 2'b00;
            7'b0100011:             ImmSrc = 2'b01;
            7'b1100011:             ImmSrc = 2'b10;
            7'b1101111:             ImmSrc = 2'b11;
            default:                ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    // sub only for R-type with funct7b5; addi ignores bit 30 of its immediate
                    3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;
    int m_state = 0;
    bit checking = 1'b0;
    int seq[$];

    logic [31:0] obs_seq;
    logic [7:0]  obs_pcw, obs_irw, obs_regw, obs_memw, obs_adr;
    logic [1:0]  obs_imm;
    logic [2:0]  obs_aluc;

    multicycle_controller #(.SUPPORT_BNE(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: per-state behaviour in terms of what each step of an
    // instruction does, independent of the RTL structure.
    always @(negedge clk) begin
        if (checking) begin
            int s;
            logic tk;
            logic [2:0] e_alu;
            logic [1:0] e_imm;
            s  = m_state;
            tk = (funct3 == 3'd0) ? zero : (funct3 == 3'd1) ? !zero : 1'b0;
            if (s == 2 || s == 1 || s == 0 || s == 10)
                e_alu = 3'd0;
            else if (s == 9)
                e_alu = 3'd1;
            else if (s == 6 || s == 7) begin
                if (funct3 == 3'd0)      e_alu = (op[5] && funct7b5) ? 3'd1 : 3'd0;
                else if (funct3 == 3'd2) e_alu = 3'd5;
                else if (funct3 == 3'd6) e_alu = 3'd3;
                else if (funct3 == 3'd7) e_alu = 3'd2;
                else                     e_alu = 3'd0;
            end else
                e_alu = 3'd0;
            if (op == 7'b0100011)      e_imm = 2'd1;
            else if (op == 7'b1100011) e_imm = 2'd2;
            else if (op == 7'b1101111) e_imm = 2'd3;
            else                       e_imm = 2'd0;
            check("state", 32'(state), 32'(s));
            check("PCWrite", 32'(PCWrite), 32'(reset && (s == 0 || s == 10 || (s == 9 && tk))));
            check("IRWrite", 32'(IRWrite), 32'(reset && s == 0));
            check("MemWrite", 32'(MemWrite), 32'(reset && s == 5));
            check("RegWrite", 32'(RegWrite), 32'(reset && (s == 4 || s == 8)));
            check("AdrSrc", 32'(AdrSrc), 32'(s == 3 || s == 5));
            check("ResultSrc", 32'(ResultSrc), (s == 0) ? 32'd2 : (s == 4) ? 32'd1 : 32'd0);
            check("ALUSrcA", 32'(ALUSrcA), (s == 1 || s == 10) ? 32'd1 :
                  (s == 2 || s == 6 || s == 7 || s == 9) ? 32'd2 : 32'd0);
            check("ALUSrcB", 32'(ALUSrcB), (s == 0 || s == 10) ? 32'd2 :
                  (s == 1 || s == 2 || s == 7) ? 32'd1 : 32'd0);
            check("ImmSrc", 32'(ImmSrc), 32'(e_imm));
            check("ALUControl", 32'(ALUControl), 32'(e_alu));
        end
    end

    // Called #1 after a rising edge with the DUT in FETCH; runs one instruction.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        seq.delete();
        seq.push_back(0);
        seq.push_back(1);
        case (o)
            7'b0000011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            7'b0100011: begin seq.push_back(2); seq.push_back(5); end
            7'b0110011: begin seq.push_back(6); seq.push_back(8); end
            7'b0010011: begin seq.push_back(7); seq.push_back(8); end
            7'b1100011: seq.push_back(9);
            7'b1101111: begin seq.push_back(10); seq.push_back(8); end
            default: ;
        endcase
        obs_seq = '0; obs_pcw = '0; obs_irw = '0; obs_regw = '0; obs_memw = '0; obs_adr = '0;
        obs_imm = '0; obs_aluc = '0;
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            obs_seq     = (obs_seq << 4) | 32'(state);
            obs_pcw[i]  = PCWrite;
            obs_irw[i]  = IRWrite;
            obs_regw[i] = RegWrite;
            obs_memw[i] = MemWrite;
            obs_adr[i]  = AdrSrc;
            if (i == 1) obs_imm = ImmSrc;
            if (i == 2) obs_aluc = ALUControl;
            @(posedge clk);
            #1;
            m_state = (i + 1 < seq.size()) ? seq[i + 1] : 0;
        end
    endtask

    initial begin
        reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);  // lw
        check("lw_seq", obs_seq, 32'h01234);
        check("lw_regwrite", 32'(obs_regw), 32'h10);
        check("lw_imm", 32'(obs_imm), 32'd0);

        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0);  // sw
        check("sw_seq", obs_seq, 32'h0125);
        check("sw_memwrite", 32'(obs_memw), 32'h08);
        check("sw_adrsrc", 32'(obs_adr), 32'h08);
        check("sw_imm", 32'(obs_imm), 32'd1);

        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);  // sub
        check("sub_seq", obs_seq, 32'h0168);
        check("sub_aluc", 32'(obs_aluc), 32'd1);
        check("sub_regwrite", 32'(obs_regw), 32'h08);

        run_instr(7'b0110011, 3'd7, 1'b0, 1'b1);  // and
        check("and_aluc", 32'(obs_aluc), 32'd2);

        run_instr(7'b0010011, 3'd2, 1'b0, 1'b0);  // slti
        check("slti_seq", obs_seq, 32'h0178);
        check("slti_aluc", 32'(obs_aluc), 32'd5);

        run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);  // addi with imm bit 30 set
        check("addi_aluc", 32'(obs_aluc), 32'd0);

        run_instr(7'b0110011, 3'd6, 1'b0, 1'b0);  // or
        check("or_aluc", 32'(obs_aluc), 32'd3);

        run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);  // beq taken
        check("beq_seq", obs_seq, 32'h019);
        check("beq_taken_pcw", 32'(obs_pcw), 32'h5);
        check("beq_imm", 32'(obs_imm), 32'd2);
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b0);  // beq not taken
        check("beq_nt_pcw", 32'(obs_pcw), 32'h1);
        run_instr(7'b1100011, 3'd1, 1'b0, 1'b0);  // bne taken
        check("bne_taken_pcw", 32'(obs_pcw), 32'h5);
        run_instr(7'b1100011, 3'd1, 1'b0, 1'b1);  // bne not taken
        check("bne_nt_pcw", 32'(obs_pcw), 32'h1);
        run_instr(7'b1100011, 3'd4, 1'b0, 1'b1);  // blt unsupported
        check("blt_pcw", 32'(obs_pcw), 32'h1);

        run_instr(7'b1101111, 3'd0, 1'b0, 1'b0);  // jal
        check("jal_seq", obs_seq, 32'h01A8);
        check("jal_pcw", 32'(obs_pcw), 32'h5);
        check("jal_imm", 32'(obs_imm), 32'd3);

        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0);  // unsupported op
        check("nop_seq", obs_seq, 32'h01);
        check("nop_pcw", 32'(obs_pcw), 32'h1);

        // lw aborted by reset while in MEMREAD
        op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            m_state = k;
        end
        check("pre_abort_state", 32'(state), 32'd3);
        #2;
        reset = 1'b0;
        m_state = 0;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        @(posedge clk);
        #1;
        check("abort_hold_state", 32'(state), 32'd0);
        reset = 1'b1;

        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);
        check("post_reset_seq", obs_seq, 32'h01234);
        check("post_reset_fetch", 32'({obs_irw[0], obs_pcw[0]}), 32'h3);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter SUPPORT_BNE, default 1: when 1, funct3=001 on the branch opcode SHALL be decoded as bne.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports op (input, 7 bits), funct3 (input, 3 bits) and funct7b5 (input, 1 bit): fields of the latched instruction register.
REQ-005 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 The block SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite and RegWrite, 1 bit each: datapath enables and selects.
REQ-007 The block SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, 2 bits each: mux selects and immediate format select.
REQ-008 The block SHALL have outputs ALUControl (3 bits, ALU operation) and state (4 bits, current FSM state, debug).

Function
REQ-009 The block SHALL implement a Moore FSM with the encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10; the codes 11-15 SHALL go to FETCH on the next edge.
REQ-010 The block SHALL implement these transitions: FETCH->DECODE; DECODE by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BRANCH, 1101111->JAL, any other op->FETCH (treated as nop).
REQ-011 The block SHALL implement these transitions: MEMADR->MEMREAD if op[5]=0, else MEMWRITE; MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; JAL->ALUWB; MEMWB, MEMWRITE, ALUWB and BRANCH->FETCH.
REQ-012 The block SHALL take these cycles per instruction, FETCH through the last state: lw 5, sw 4, R 4, I 4, branch 3, jal 4, unsupported op 2.
REQ-013 The block SHALL drive these state outputs; any output not listed SHALL be 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-014 The block SHALL compute PCWrite = PCUpdate OR (Branch AND taken) combinationally, where taken is zero for funct3=000, (NOT zero) for funct3=001 when SUPPORT_BNE=1, and 0 for any other funct3.
REQ-015 The block SHALL decode ImmSrc combinationally from op in every state: 0000011 or 0010011->00 (I), 0100011->01 (S), 1100011->10 (B), 1101111->11 (J), any other op->00.
REQ-016 The block SHALL decode ALUControl combinationally from ALUOp, funct3 and funct7b5:
- ALUOp=00 gives 000 (add); ALUOp=01 gives 001 (sub).
- ALUOp=10 with funct3=000 gives 001 when op[5]=1 and funct7b5=1, otherwise 000.
- ALUOp=10 with funct3=010 gives 101 (slt), 110 gives 011 (or), 111 gives 010 (and), any other funct3 gives 000.
REQ-017 The block SHALL keep ALUOp, PCUpdate and Branch internal.
REQ-018 The block SHALL NOT depend on zero for state transitions; zero SHALL affect PCWrite in BRANCH only.

Reset
REQ-019 While reset=0, the block SHALL hold state=FETCH asynchronously and force PCWrite, IRWrite, MemWrite and RegWrite to 0; all other outputs SHALL show their FETCH values and combinational decodes.
REQ-020 When reset is asserted mid-instruction, the block SHALL abort it immediately with no further write enables; after reset deasserts, the first rising edge SHALL execute FETCH with IRWrite=1 and PCWrite=1.

Verification
REQ-021 The bench SHALL cover: reset released, then lw (op=0000011) -> state 0,1,2,3,4,0; RegWrite=1 only in state 4; ImmSrc=00 throughout.
REQ-022 The bench SHALL cover: sw (op=0100011) -> state 0,1,2,5,0; MemWrite=1 only in state 5 with AdrSrc=1; ImmSrc=01.
REQ-023 The bench SHALL cover: R-type with funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; with funct3=111 -> 010; ALUWB RegWrite=1.
REQ-024 The bench SHALL cover: beq with zero=1 -> PCWrite=1 in BRANCH; zero=0 -> PCWrite=0; bne (funct3=001) with zero=0 -> PCWrite=1; funct3=100 -> PCWrite=0.
REQ-025 The bench SHALL cover: jal (op=1101111) -> state 0,1,10,8,0; PCWrite=1 in state 10; ImmSrc=11.
REQ-026 The bench SHALL cover: op=1111111 -> state 0,1,0; then reset pulsed low in MEMREAD -> state=0 immediately, all write enables 0 while reset=0.
